// File: rtl/alu_add_seq.sv
// Operand sequencer for the 8-bit latched adder: latches A, presents B, captures the result
// and holds it on a valid/ready response port. Optional feature macro: CARRY_CHAIN_EN.
module alu_add_seq #(
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_cin,
    input  logic              req_chain,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic [DATA_W-1:0] alu_in_data,
    output logic              alu_cin,
    output logic              alu_lock_in_data,
    output logic              alu_lock_out_data,
    input  logic [DATA_W-1:0] alu_out_data,
    input  logic              alu_cout,
    output logic              busy,
    output logic [STAT_W-1:0] op_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_ADD    = 3'd2;
    localparam logic [2:0] ST_CAPT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [STAT_W-1:0] CNT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic              op_cin_r;
    logic [DATA_W-1:0] op_a_nxt_s;
    logic [DATA_W-1:0] op_b_nxt_s;
    logic              op_cin_nxt_s;
    logic              cin_sel_s;
    logic              accept_s;
    logic              rsp_hs_s;

    logic              req_ready_r;
    logic              busy_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_sum_r;
    logic              rsp_cout_r;
    logic [STAT_W-1:0] op_count_r;

    logic [DATA_W-1:0] alu_in_data_r;
    logic              alu_cin_r;
    logic              alu_lock_in_r;
    logic              alu_lock_out_r;
    logic [DATA_W-1:0] alu_in_data_nxt_s;
    logic              alu_cin_nxt_s;
    logic              alu_lock_in_nxt_s;
    logic              alu_lock_out_nxt_s;

    assign accept_s = req_valid & req_ready_r;
    assign rsp_hs_s = rsp_valid_r & rsp_ready;

`ifdef CARRY_CHAIN_EN
    logic carry_r;

    assign cin_sel_s = req_chain ? carry_r : req_cin;

    // Carry of the last consumed response, feeding chained multi-byte adds
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else if (rsp_hs_s) begin
            carry_r <= rsp_cout_r;
        end else begin
            carry_r <= carry_r;
        end
    end
`else
    logic unused_chain_s;

    assign unused_chain_s = req_chain;
    assign cin_sel_s      = req_cin;
`endif

    // Next-state decode of the five-step add sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_LOAD_A;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_A: state_nxt_s = ST_ADD;
            ST_ADD:    state_nxt_s = ST_CAPT;
            ST_CAPT:   state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Operand capture values; only an accepted request replaces them
    always_comb begin
        op_a_nxt_s   = op_a_r;
        op_b_nxt_s   = op_b_r;
        op_cin_nxt_s = op_cin_r;
        if (accept_s) begin
            op_a_nxt_s   = req_a;
            op_b_nxt_s   = req_b;
            op_cin_nxt_s = cin_sel_s;
        end else begin
            op_a_nxt_s   = op_a_r;
            op_b_nxt_s   = op_b_r;
            op_cin_nxt_s = op_cin_r;
        end
    end

    // Adder controls decoded from the next state so the registered outputs line up with it
    always_comb begin
        alu_in_data_nxt_s  = DATA_ZERO;
        alu_cin_nxt_s      = 1'b0;
        alu_lock_in_nxt_s  = 1'b0;
        alu_lock_out_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_LOAD_A: begin
                alu_in_data_nxt_s = op_a_nxt_s;
                alu_lock_in_nxt_s = 1'b1;
            end
            ST_ADD: begin
                alu_in_data_nxt_s  = op_b_nxt_s;
                alu_cin_nxt_s      = op_cin_nxt_s;
                alu_lock_out_nxt_s = 1'b1;
            end
            default: begin
                alu_in_data_nxt_s  = DATA_ZERO;
                alu_cin_nxt_s      = 1'b0;
                alu_lock_in_nxt_s  = 1'b0;
                alu_lock_out_nxt_s = 1'b0;
            end
        endcase
    end

    // State, operand registers and the handshake/status flags derived from state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_a_r      <= DATA_ZERO;
            op_b_r      <= DATA_ZERO;
            op_cin_r    <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            op_a_r      <= op_a_nxt_s;
            op_b_r      <= op_b_nxt_s;
            op_cin_r    <= op_cin_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Registered adder data and one-cycle lock pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in_data_r  <= DATA_ZERO;
            alu_cin_r      <= 1'b0;
            alu_lock_in_r  <= 1'b0;
            alu_lock_out_r <= 1'b0;
        end else begin
            alu_in_data_r  <= alu_in_data_nxt_s;
            alu_cin_r      <= alu_cin_nxt_s;
            alu_lock_in_r  <= alu_lock_in_nxt_s;
            alu_lock_out_r <= alu_lock_out_nxt_s;
        end
    end

    // Result capture one cycle after the result lock, held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_sum_r   <= DATA_ZERO;
            rsp_cout_r  <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if (state_r == ST_CAPT) begin
                rsp_sum_r  <= alu_out_data;
                rsp_cout_r <= alu_cout;
            end else begin
                rsp_sum_r  <= rsp_sum_r;
                rsp_cout_r <= rsp_cout_r;
            end
        end
    end

    // Saturating count of consumed responses
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_r <= {STAT_W{1'b0}};
        end else if (rsp_hs_s && (op_count_r != CNT_MAX)) begin
            op_count_r <= op_count_r + CNT_ONE;
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign req_ready         = req_ready_r;
    assign busy              = busy_r;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_sum           = rsp_sum_r;
    assign rsp_cout          = rsp_cout_r;
    assign op_count          = op_count_r;
    assign alu_in_data       = alu_in_data_r;
    assign alu_cin           = alu_cin_r;
    assign alu_lock_in_data  = alu_lock_in_r;
    assign alu_lock_out_data = alu_lock_out_r;

endmodule

// File: tb/tb_alu_add_seq.sv
// Scoreboard bench for alu_add_seq with a behavioural model of the latched adder stage.
// Expected chained-carry results follow CARRY_CHAIN_EN.
module tb_alu_add_seq;

    localparam int DATA_W = 8;
    localparam int STAT_W = 2;

`ifdef CARRY_CHAIN_EN
    localparam logic [7:0] EXP_CHAIN1 = 8'h01;
    localparam logic [7:0] EXP_CHAIN2 = 8'h0A;
`else
    localparam logic [7:0] EXP_CHAIN1 = 8'h00;
    localparam logic [7:0] EXP_CHAIN2 = 8'h0B;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_a = 8'h00;
    logic [DATA_W-1:0] req_b = 8'h00;
    logic              req_cin = 1'b0;
    logic              req_chain = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_cout;
    logic [DATA_W-1:0] alu_in_data;
    logic              alu_cin;
    logic              alu_lock_in_data;
    logic              alu_lock_out_data;
    logic [DATA_W-1:0] alu_out_data;
    logic              alu_cout;
    logic              busy;
    logic [STAT_W-1:0] op_count;

    always #5 clk = ~clk;

    alu_add_seq #(.DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .alu_in_data(alu_in_data), .alu_cin(alu_cin),
        .alu_lock_in_data(alu_lock_in_data), .alu_lock_out_data(alu_lock_out_data),
        .alu_out_data(alu_out_data), .alu_cout(alu_cout),
        .busy(busy), .op_count(op_count)
    );

    // Latched adder stage: no reset, A on lock_in_data, result on lock_out_data
    logic [7:0] add_a = 8'h00;
    logic [7:0] add_sum = 8'h00;
    logic       add_cout = 1'b0;
    always @(posedge clk) begin
        if (alu_lock_in_data) add_a <= alu_in_data;
        if (alu_lock_out_data) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, alu_in_data} + {8'h00, alu_cin};
    end
    assign alu_out_data = add_sum;
    assign alu_cout     = add_cout;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_cnt = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops, response hold, lock pulse shape and counter
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
    logic [7:0] prev_sum = 8'h00;
    logic       prev_cout = 1'b0, prev_lock_in = 1'b0, prev_lock_out = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("op_count", {30'd0, op_count}, {30'd0, exp_cnt});
            if (prev_valid && !prev_ready && !prev_rst)
                chk("rsp_hold", {rsp_valid, rsp_sum, rsp_cout}, {1'b1, prev_sum, prev_cout});
            if (alu_lock_in_data || alu_lock_out_data)
                chk("lock_pulse", {alu_lock_in_data && prev_lock_in, alu_lock_out_data && prev_lock_out,
                                   alu_lock_in_data && alu_lock_out_data}, 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_sum_cout", {rsp_sum, rsp_cout}, {e.sum, e.cout});
                end
                if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            end
        end else begin
            exp_q.delete();
            exp_cnt = 2'd0;
        end
        prev_valid    = rsp_valid;
        prev_ready    = rsp_ready;
        prev_rst      = rst;
        prev_sum      = rsp_sum;
        prev_cout     = rsp_cout;
        prev_lock_in  = alu_lock_in_data;
        prev_lock_out = alu_lock_out_data;
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic chain,
                         input logic [7:0] es, input logic ec, input int stall);
        exp_t e;
        wait_ready();
        req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; req_chain = chain;
        e.sum = es; e.cout = ec;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; req_chain = 1'b0; req_cin = 1'b0;
        chk("load_a", {alu_lock_in_data, alu_lock_out_data, alu_in_data}, {1'b1, 1'b0, a});
        @(posedge clk); #1;
        chk("add_b", {alu_lock_in_data, alu_lock_out_data, alu_in_data}, {1'b0, 1'b1, b});
        @(posedge clk); #1;
        chk("capt_state", {req_ready, rsp_valid, busy, alu_lock_in_data, alu_lock_out_data, alu_in_data},
            {5'b00100, 8'h00});
        @(posedge clk); #1;
        chk("latency_valid", {req_ready, rsp_valid, busy}, 3'b011);
        for (int i = 0; i < stall; i++) begin
            // A competing request must not be accepted while the response is held
            req_valid = 1'b1; req_a = 8'hEE; req_b = 8'hEE;
            @(posedge clk); #1;
            chk("stall_state", {req_ready, rsp_valid, busy}, 3'b011);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("after_handshake", {req_ready, rsp_valid, busy}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {req_ready, rsp_valid, busy, alu_lock_in_data, alu_lock_out_data, alu_cin},
            6'b100000);
        chk("reset_data", {rsp_sum, rsp_cout, alu_in_data, op_count}, 32'd0);
        @(posedge clk); #1;

        // 0x3C+0x42 with a six-cycle consumer stall
        issue(8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 6);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        issue(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 0);
        issue(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 0);
        issue(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        chk("op_count_sat", {30'd0, op_count}, 32'd3);

        // Reset while the sequencer sits in ADD discards the pending result
        wait_ready();
        req_valid = 1'b1; req_a = 8'h11; req_b = 8'h22; req_cin = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_add", {alu_lock_out_data, busy}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_ctrl", {req_ready, rsp_valid, busy, alu_lock_in_data, alu_lock_out_data, alu_cin},
            6'b100000);
        chk("post_rst_data", {alu_in_data, op_count}, 32'd0);

        // Chain request straight after reset: the stored carry must be clear
        issue(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        issue(8'h00, 8'h00, 1'b0, 1'b1, EXP_CHAIN1, 1'b0, 0);
        issue(8'h05, 8'h05, 1'b1, 1'b1, EXP_CHAIN2, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count", {30'd0, op_count}, 32'd3);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
